pll_reset_sequencer: RTL and testbench

- Power-up and recovery controller for the video PLL (50 MHz refclk in, 25 MHz pixel clock out).
- Drives the PLL reset, qualifies its lock output and releases a system reset to the game/VGA logic only after lock has been stable.
- Re-sequences the PLL on lock loss, retries on lock timeout, and parks in a FAIL state after a bounded number of attempts.
- Runs entirely in the refclk domain.

---
 rtl/pll_reset_sequencer_if.sv | 37 +++
 rtl/pll_reset_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / downstream logic.
// The sequencer takes the master side; the PLL and consumers take the slave side.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       soft_restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       fail;
    logic       lock_lost;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;
    logic [7:0] lock_loss_cnt;

    modport master (
        input  pll_locked,
        input  soft_restart,
        output pll_rst,
        output sys_rst_n,
        output fail,
        output lock_lost,
        output retry_cnt,
        output state_o,
        output lock_loss_cnt
    );

    modport slave (
        output pll_locked,
        output soft_restart,
        input  pll_rst,
        input  sys_rst_n,
        input  fail,
        input  lock_lost,
        input  retry_cnt,
        input  state_o,
        input  lock_loss_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Video PLL reset/lock sequencer: holds the PLL in reset, qualifies lock, releases system reset.
// Define PLLSEQ_LOCK_LOSS_CNT_EN to build the saturating lock-loss event counter.
module pll_reset_sequencer #(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_reset_sequencer_if.master bus
);

    localparam int SYNC_STAGES = 2;
    localparam int CNT_MAX_A   = (RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_MAX     = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ASSERT_RST = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        RUN        = 3'd3,
        FAIL       = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       retry_reg, retry_next;
    logic             lock_lost_reg, lock_lost_next;
    logic             pll_rst_reg, sys_rst_n_reg, fail_reg;
    logic             lock_drop;
    logic             counting;

    // pll_locked is asynchronous to refclk; only the last synchronizer stage is used.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   lk_s;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge refclk) begin
                    if (!rst_n) begin
                        sync_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi] <= bus.pll_locked;
                    end
                end
            end else begin : g_next
                always_ff @(posedge refclk) begin
                    if (!rst_n) begin
                        sync_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign lk_s = sync_reg[SYNC_STAGES-1];

    always_comb begin
        state_next = state_reg;
        lock_drop  = 1'b0;
        if (bus.soft_restart) begin
            state_next = ASSERT_RST;
        end else begin
            case (state_reg)
                ASSERT_RST: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    // Lock seen on the timeout edge still wins.
                    if (lk_s) begin
                        state_next = STABLE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_next = (retry_reg == RETRY_MAX) ? FAIL : ASSERT_RST;
                    end
                end
                STABLE: begin
                    if (!lk_s) begin
                        state_next = WAIT_LOCK;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state_next = ASSERT_RST;
                        lock_drop  = 1'b1;
                    end
                end
                FAIL: begin
                    state_next = FAIL;
                end
                default: begin
                    state_next = ASSERT_RST;
                end
            endcase
        end
    end

    // One shared counter, restarted on every state entry and on soft_restart.
    always_comb begin
        counting = (state_reg == ASSERT_RST) || (state_reg == WAIT_LOCK) || (state_reg == STABLE);
        cnt_next = cnt_reg;
        if (bus.soft_restart || (state_next != state_reg)) begin
            cnt_next = '0;
        end else if (counting) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_comb begin
        retry_next = retry_reg;
        if (bus.soft_restart) begin
            retry_next = '0;
        end else if (state_reg == STABLE && state_next == RUN) begin
            retry_next = '0;
        end else if (state_reg == WAIT_LOCK && state_next == ASSERT_RST && retry_reg != RETRY_MAX) begin
            retry_next = retry_reg + 2'd1;
        end
    end

    always_comb begin
        lock_lost_next = lock_lost_reg;
        if (bus.soft_restart) begin
            lock_lost_next = 1'b0;
        end else if (lock_drop) begin
            lock_lost_next = 1'b1;
        end
    end

    // Outputs decode next-state so they move on the same edge as the state register.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_reg     <= ASSERT_RST;
            cnt_reg       <= '0;
            retry_reg     <= '0;
            lock_lost_reg <= 1'b0;
            pll_rst_reg   <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            fail_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            retry_reg     <= retry_next;
            lock_lost_reg <= lock_lost_next;
            pll_rst_reg   <= (state_next == ASSERT_RST);
            sys_rst_n_reg <= (state_next == RUN);
            fail_reg      <= (state_next == FAIL);
        end
    end

`ifdef PLLSEQ_LOCK_LOSS_CNT_EN
    logic [7:0] loss_cnt_reg;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            loss_cnt_reg <= 8'd0;
        end else if (lock_drop && loss_cnt_reg != 8'hFF) begin
            loss_cnt_reg <= loss_cnt_reg + 8'd1;
        end
    end

    assign bus.lock_loss_cnt = loss_cnt_reg;
`else
    assign bus.lock_loss_cnt = 8'd0;
`endif

    assign bus.pll_rst   = pll_rst_reg;
    assign bus.sys_rst_n = sys_rst_n_reg;
    assign bus.fail      = fail_reg;
    assign bus.lock_lost = lock_lost_reg;
    assign bus.retry_cnt = retry_reg;
    assign bus.state_o   = state_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scenario bench for pll_reset_sequencer: expectations are queued when stimulus is
// applied and popped when the sequencer responds.
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES          = 4;
    localparam int LOCK_TIMEOUT_CYCLES = 20;
    localparam int LOCK_STABLE_CYCLES  = 8;
    localparam int MAX_RETRIES         = 2;
`ifdef PLLSEQ_LOCK_LOSS_CNT_EN
    localparam int LLC_EN = 1;
`else
    localparam int LLC_EN = 0;
`endif

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;

    pll_reset_sequencer_if seq_if ();

    pll_reset_sequencer #(
        .RST_CYCLES          (RST_CYCLES),
        .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
        .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
        .MAX_RETRIES         (MAX_RETRIES)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (seq_if.master)
    );

    always #5 refclk = ~refclk;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // {pll_rst, sys_rst_n, fail, lock_lost, retry_cnt, state_o, lock_loss_cnt}
    function automatic logic [31:0] status();
        return {15'd0, seq_if.pll_rst, seq_if.sys_rst_n, seq_if.fail, seq_if.lock_lost,
                seq_if.retry_cnt, seq_if.state_o, seq_if.lock_loss_cnt};
    endfunction

    function automatic logic [31:0] mk(input int p, input int s, input int f, input int l,
                                       input int r, input int st, input int c);
        return {15'd0, 1'(p), 1'(s), 1'(f), 1'(l), 2'(r), 3'(st), 8'(c)};
    endfunction

    task automatic test_reset();
        logic [31:0] exp_v, obs_v;
        rst_n = 1'b0;
        seq_if.pll_locked   = 1'b0;
        seq_if.soft_restart = 1'b0;
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        repeat (3) tick();
        exp_v = exp_q.pop_front(); obs_v = status(); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL reset_state: got %h expected %h", obs_v, exp_v); end
        else $display("ok   reset_state: %h", obs_v);
    endtask

    task automatic test_power_up();
        logic [31:0] exp_v, obs_v;
        int width = 0;
        int edges = 0;
        exp_q.push_back(32'(RST_CYCLES));
        exp_q.push_back(32'(LOCK_STABLE_CYCLES + 3));
        exp_q.push_back(mk(0, 1, 0, 0, 0, 3, 0));
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            if (seq_if.pll_rst === 1'b1) width++;
            tick();
        end
        seq_if.pll_locked = 1'b1;
        exp_v = exp_q.pop_front(); obs_v = 32'(width); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL powerup_pll_rst_width: got %0d expected %0d", obs_v, exp_v); end
        else $display("ok   powerup_pll_rst_width: %0d", obs_v);
        while (seq_if.sys_rst_n !== 1'b1 && edges < 100) begin
            tick();
            edges++;
        end
        exp_v = exp_q.pop_front(); obs_v = 32'(edges); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL powerup_release_edge: got %0d expected %0d", obs_v, exp_v); end
        else $display("ok   powerup_release_edge: %0d", obs_v);
        exp_v = exp_q.pop_front(); obs_v = status(); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL powerup_run_state: got %h expected %h", obs_v, exp_v); end
        else $display("ok   powerup_run_state: %h", obs_v);
    endtask

    task automatic test_lock_loss();
        logic [31:0] exp_v, obs_v;
        logic [31:0] fall_status = '0;
        int fall_t = -1;
        int rise_t = -1;
        int width  = 0;
        exp_q.push_back(32'd3);
        exp_q.push_back(mk(1, 0, 0, 1, 0, 0, LLC_EN));
        exp_q.push_back(32'(RST_CYCLES));
        exp_q.push_back(32'd17);
        exp_q.push_back(mk(0, 1, 0, 1, 0, 3, LLC_EN));
        seq_if.pll_locked = 1'b0;
        for (int t = 1; t <= 60 && rise_t < 0; t++) begin
            tick();
            if (t == 6) seq_if.pll_locked = 1'b1;
            if (seq_if.pll_rst === 1'b1) width++;
            if (fall_t < 0 && seq_if.sys_rst_n === 1'b0) begin
                fall_t = t;
                fall_status = status();
            end else if (fall_t >= 0 && seq_if.sys_rst_n === 1'b1) begin
                rise_t = t;
            end
        end
        exp_v = exp_q.pop_front(); obs_v = 32'(fall_t); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL lockloss_fall_edge: got %0d expected %0d", $signed(obs_v), exp_v); end
        else $display("ok   lockloss_fall_edge: %0d", obs_v);
        exp_v = exp_q.pop_front(); obs_v = fall_status; vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL lockloss_flags: got %h expected %h", obs_v, exp_v); end
        else $display("ok   lockloss_flags: %h", obs_v);
        exp_v = exp_q.pop_front(); obs_v = 32'(width); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL lockloss_pll_rst_width: got %0d expected %0d", obs_v, exp_v); end
        else $display("ok   lockloss_pll_rst_width: %0d", obs_v);
        exp_v = exp_q.pop_front(); obs_v = 32'(rise_t); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL lockloss_rerelease_edge: got %0d expected %0d", $signed(obs_v), exp_v); end
        else $display("ok   lockloss_rerelease_edge: %0d", obs_v);
        exp_v = exp_q.pop_front(); obs_v = status(); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL lockloss_run_state: got %h expected %h", obs_v, exp_v); end
        else $display("ok   lockloss_run_state: %h", obs_v);
    endtask

    task automatic test_never_locks();
        logic [31:0] exp_v, obs_v;
        logic [31:0] width_q[$];
        logic level = 1'b1;
        bit   saw_sys = 1'b0;
        int   run = 0;
        int   t   = 0;
        width_q = '{32'd4, 32'd20, 32'd4, 32'd20, 32'd4, 32'd20};
        exp_q.push_back(32'd72);
        exp_q.push_back(32'd0);
        exp_q.push_back(mk(0, 0, 1, 1, MAX_RETRIES, 4, 2 * LLC_EN));
        exp_q.push_back(mk(0, 0, 1, 1, MAX_RETRIES, 4, 2 * LLC_EN));
        seq_if.pll_locked = 1'b0;
        while (seq_if.pll_rst !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        vectors++;
        if (t >= 20) begin miscompares++; $display("FAIL nolock_first_pulse: got no pll_rst within %0d cycles expected one", t); end
        else $display("ok   nolock_first_pulse: after %0d cycles", t);
        t = 0;
        while (seq_if.fail !== 1'b1 && t < 200) begin
            run++;
            tick();
            t++;
            if (seq_if.sys_rst_n !== 1'b0) saw_sys = 1'b1;
            if (seq_if.pll_rst !== level || seq_if.fail === 1'b1) begin
                vectors++;
                if (width_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL nolock_extra_phase: got run of %0d expected none", run);
                end else begin
                    exp_v = width_q.pop_front();
                    if (32'(run) !== exp_v) begin miscompares++; $display("FAIL nolock_phase_width: got %0d expected %0d", run, exp_v); end
                    else $display("ok   nolock_phase_width: %0d", run);
                end
                level = ~level;
                run = 0;
            end
        end
        exp_v = exp_q.pop_front(); obs_v = 32'(t); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL nolock_fail_edge: got %0d expected %0d", obs_v, exp_v); end
        else $display("ok   nolock_fail_edge: %0d", obs_v);
        exp_v = exp_q.pop_front(); obs_v = 32'(saw_sys); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL nolock_sys_rst_n_high: got %0d expected %0d", obs_v, exp_v); end
        else $display("ok   nolock_sys_rst_n_high: %0d", obs_v);
        exp_v = exp_q.pop_front(); obs_v = status(); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL nolock_fail_state: got %h expected %h", obs_v, exp_v); end
        else $display("ok   nolock_fail_state: %h", obs_v);
        repeat (30) tick();
        exp_v = exp_q.pop_front(); obs_v = status(); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL nolock_fail_sticky: got %h expected %h", obs_v, exp_v); end
        else $display("ok   nolock_fail_sticky: %h", obs_v);
    endtask

    task automatic test_soft_restart();
        logic [31:0] exp_v, obs_v;
        int width = 0;
        int t     = 0;
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 2 * LLC_EN));
        exp_q.push_back(32'(RST_CYCLES));
        seq_if.soft_restart = 1'b1;
        tick();
        seq_if.soft_restart = 1'b0;
        exp_v = exp_q.pop_front(); obs_v = status(); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL soft_from_fail: got %h expected %h", obs_v, exp_v); end
        else $display("ok   soft_from_fail: %h", obs_v);
        tick();
        seq_if.soft_restart = 1'b1;
        tick();
        seq_if.soft_restart = 1'b0;
        while (seq_if.pll_rst === 1'b1 && t < 20) begin
            width++;
            tick();
            t++;
        end
        exp_v = exp_q.pop_front(); obs_v = 32'(width); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL soft_mid_rst_width: got %0d expected %0d", obs_v, exp_v); end
        else $display("ok   soft_mid_rst_width: %0d", obs_v);
    endtask

    task automatic test_chattering();
        logic [31:0] exp_v, obs_v;
        logic [31:0] s7 = '0;
        logic [31:0] s8 = '0;
        int rise_t = -1;
        int t      = 0;
        exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 2 * LLC_EN));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2, 2 * LLC_EN));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 2 * LLC_EN));
        exp_q.push_back(32'd18);
        exp_q.push_back(mk(0, 1, 0, 0, 0, 3, 2 * LLC_EN));
        seq_if.pll_locked = 1'b0;
        while (seq_if.pll_rst !== 1'b1 && t < 40) begin tick(); t++; end
        while (seq_if.pll_rst === 1'b1 && t < 60) begin tick(); t++; end
        exp_v = exp_q.pop_front(); obs_v = status(); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL chatter_after_timeout: got %h expected %h", obs_v, exp_v); end
        else $display("ok   chatter_after_timeout: %h", obs_v);
        for (int e = 1; e <= 40 && rise_t < 0; e++) begin
            seq_if.pll_locked = (e <= 5 || e >= 8);
            tick();
            if (e == 7) s7 = status();
            if (e == 8) s8 = status();
            if (seq_if.sys_rst_n === 1'b1) rise_t = e;
        end
        exp_v = exp_q.pop_front(); obs_v = s7; vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL chatter_in_stable: got %h expected %h", obs_v, exp_v); end
        else $display("ok   chatter_in_stable: %h", obs_v);
        exp_v = exp_q.pop_front(); obs_v = s8; vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL chatter_abort: got %h expected %h", obs_v, exp_v); end
        else $display("ok   chatter_abort: %h", obs_v);
        exp_v = exp_q.pop_front(); obs_v = 32'(rise_t); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL chatter_release_edge: got %0d expected %0d", $signed(obs_v), exp_v); end
        else $display("ok   chatter_release_edge: %0d", obs_v);
        exp_v = exp_q.pop_front(); obs_v = status(); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL chatter_run_state: got %h expected %h", obs_v, exp_v); end
        else $display("ok   chatter_run_state: %h", obs_v);
    endtask

    task automatic test_rst_during_run();
        logic [31:0] exp_v, obs_v;
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        tick();
        exp_v = exp_q.pop_front(); obs_v = status(); vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL rst_in_run: got %h expected %h", obs_v, exp_v); end
        else $display("ok   rst_in_run: %h", obs_v);
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss();
        test_never_locks();
        test_soft_restart();
        test_chattering();
        test_rst_during_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
